// File: rtl/gpio_input_debouncer_if.sv
// GPIO conditioning bus: raw pad levels and bypass in, debounced level and edge pulses out.
interface gpio_input_debouncer_if #(
  parameter int GPIO_WIDTH = 3
);
  logic [GPIO_WIDTH-1:0] raw_input;
  logic [GPIO_WIDTH-1:0] bypass;
  logic [GPIO_WIDTH-1:0] stable_output;
  logic [GPIO_WIDTH-1:0] rise_pulse;
  logic [GPIO_WIDTH-1:0] fall_pulse;

  modport master (
    output raw_input, bypass,
    input  stable_output, rise_pulse, fall_pulse
  );

  modport slave (
    input  raw_input, bypass,
    output stable_output, rise_pulse, fall_pulse
  );
endinterface

// File: rtl/gpio_input_debouncer.sv
// Per-pin 2-flop synchronizer + saturating stability filter for GPIO inputs.
// Optional rise/fall pulse registers enabled by `define GPIO_DEBOUNCE_EDGE_EN.
module gpio_input_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic bypass,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0, sync1, stable_q;
  logic [CW-1:0] count;
  logic          accept;

  // Bypass accepts any difference immediately; otherwise wait for a full stable run.
  assign accept = (sync1 != stable_q) && (bypass || (count == LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      stable_q <= 1'b0;
      count    <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      if (bypass || (sync1 == stable_q) || (count == LAST))
        count <= '0;
      else
        count <= count + 1'b1;
      if (accept)
        stable_q <= sync1;
    end
  end

  assign stable = stable_q;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept &  sync1;
      fall_q <= accept & ~sync1;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

module gpio_input_debouncer #(
  parameter int GPIO_WIDTH      = 3,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic                  clock,
  input  logic                  reset,
  gpio_input_debouncer_if.slave gpio
);
  logic [GPIO_WIDTH-1:0] stable_w, rise_w, fall_w;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_lane
    gpio_input_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clock  (clock),
      .reset  (reset),
      .raw    (gpio.raw_input[i]),
      .bypass (gpio.bypass[i]),
      .stable (stable_w[i]),
      .rise   (rise_w[i]),
      .fall   (fall_w[i])
    );
  end

  assign gpio.stable_output = stable_w;
  assign gpio.rise_pulse    = rise_w;
  assign gpio.fall_pulse    = fall_w;
endmodule

// File: doc/gpio_input_debouncer.md
# gpio_input_debouncer

Per-pin input conditioning stage between the board's GPIO pads and the `gpio_input` bus of the RVX core. Each bit is synchronized into the `clock` domain with two flops and filtered by a saturating stability counter. Each bit also produces single-cycle rise/fall pulses. The block replaces the single-flop pad sampling in board top levels, so that software polling GPIO reads bounce-free levels.

## Interface
- `GPIO_WIDTH`, 3, number of independent input bits.
- `DEBOUNCE_CYCLES`, 120000, consecutive stable cycles required before a change is accepted (10 ms at 12 MHz); legal range ≥ 1.
- `clock`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high; clears all state.
- `raw_input`  input  GPIO_WIDTH  asynchronous pad levels.
- `bypass`  input  GPIO_WIDTH  per-bit: 1 = skip the filter (synchronizer only). Board tops tie this to `gpio_oe`.
- `stable_output`  output  GPIO_WIDTH  debounced level, drives core `gpio_input`.
- `rise_pulse`  output  GPIO_WIDTH  one-cycle pulse on accepted 0→1.
- `fall_pulse`  output  GPIO_WIDTH  one-cycle pulse on accepted 1→0.

## Operation
- Per bit i, independent state: `sync0`, `sync1`, `stable`, `count`. `count` width is clog2(DEBOUNCE_CYCLES+1).
- Synchronizer: `sync0 <= raw_input[i]`, `sync1 <= sync0` every cycle.
- Filter, when `bypass[i]`=0:
  - `sync1 == stable`: `count <= 0`.
  - `sync1 != stable` and `count < DEBOUNCE_CYCLES-1`: `count <= count+1`.
  - `sync1 != stable` and `count == DEBOUNCE_CYCLES-1`: `stable <= sync1`, `count <= 0`, and pulse.
- Glitch rejection: any return of `sync1` to `stable` before acceptance zeroes `count`. There is no partial credit.
- Bypass, when `bypass[i]`=1:
  - `stable <= sync1` every cycle, and `count <= 0`.
  - A level change still pulses.
  - Toggling `bypass` takes effect on the next edge.
  - When `bypass` falls, filtering restarts from the current `stable` with `count`=0.
- Pulses:
  - Registered outputs.
  - `rise_pulse[i]` is high for exactly the cycle after `stable` changes 0→1. `fall_pulse[i]` likewise for 1→0.
  - The two pulses are never high together.
- Reset:
  - All `sync*`, `stable`, `count` and pulse registers are cleared to 0 on any edge with `reset`=1, including mid-count.
  - `stable_output`, `rise_pulse` and `fall_pulse` read 0 while in reset.
  - A pin held high across reset release produces a `rise_pulse` after the normal latency.

## Timing
- Edge numbering: edge 0 is the first rising edge sampling a new `raw_input` level, with the level held afterwards.
- Filtered latency: `sync1` changes at edge 1 and `count` increments from edge 2. `stable_output` changes at edge DEBOUNCE_CYCLES+1. The pulse is visible in the cycle following that edge.
- DEBOUNCE_CYCLES=1: `stable_output` changes at edge 2.
- Bypass latency: `stable_output` changes at edge 2.
- Throughput: a new transition can begin qualifying on the cycle after acceptance. The minimum accepted-toggle period is DEBOUNCE_CYCLES cycles.
- No combinational path from any input to any output.

## Configuration
- `GPIO_DEBOUNCE_EDGE_EN` defined: pulse registers and edge logic are present, as described above.
- Undefined:
  - `rise_pulse` and `fall_pulse` are tied to constant 0 and no pulse flops are synthesized.
  - The filter and `stable_output` behaviour are unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and GPIO_WIDTH=3.

- Clean edge: `raw_input` 000→001 held at edge 0 → `stable_output`=001 from edge 5, `rise_pulse`=001 for exactly one cycle, other bits 0.
- Glitch: bit 1 high for 3 cycles, then low → `stable_output` stays 000 and no pulses. Then hold high for 10 cycles → accepted at edge 5 of that hold.
- Fall plus simultaneous bits: all bits 111 stable, then `raw_input`=000 → `stable_output`=000 at edge 5 and `fall_pulse`=111 for one cycle.
- Bypass: `bypass`=010, bit 1 toggles every 2 cycles → `stable_output[1]` follows with a 2-edge lag and pulses on every toggle. Bits 0 and 2 remain filtered.
- Reset mid-count: bit 2 rises, `reset`=1 at edge 3 for 1 cycle, bit 2 kept high → outputs 0 during reset. Accepted 5 edges after reset release with `rise_pulse`=100.
- Macro off: rerun the clean-edge case without `GPIO_DEBOUNCE_EDGE_EN` → identical `stable_output`, pulses constantly 000.
